uart_tx: RTL

UART_TX -- requirements
Module: uart_tx

---
 rtl/uart_tx.sv | 231 +++++++++++++++++++++++
 1 files changed

// File: rtl/uart_tx.sv
// UART transmitter: byte FIFO (or single holding register) feeding a
// start/data/parity/stop serializer paced by an OSR-times-baud tick enable.
//
//   state  | meaning
//   IDLE   | line high; pops the next byte on a tick when storage is non-empty
//   START  | start bit (low) for OSR ticks
//   DATA   | 5..8 data bits, LSB first, OSR ticks each
//   PARITY | optional parity bit, OSR ticks
//   STOP   | line high; 1, 1.5 or 2 bit periods including the popping IDLE tick
module uart_tx #(
   parameter int FIFO_DEPTH = 16,
   parameter int OSR        = 16
) (
   input  logic                          apb_clk_in,
   input  logic                          apb_rst_in,
   input  logic                          bclk_in,
   input  logic [7:0]                    thr_in,
   input  logic                          thr_wr_in,
   input  logic                          fifoen_in,
   input  logic                          txclr_in,
   input  logic                          utrst_in,
   input  logic [1:0]                    wls_in,
   input  logic                          stb_in,
   input  logic                          pen_in,
   input  logic                          eps_in,
   input  logic                          sp_in,
   input  logic                          bc_in,
   output logic                          uart_txd_out,
   output logic                          thre_out,
   output logic                          temt_out,
   output logic [$clog2(FIFO_DEPTH):0]   tx_level_out,
   output logic                          tx_ovf_out
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int LW = PW + 1;
   localparam int TW = $clog2(2 * OSR);
   localparam logic [TW-1:0] BIT_LOAD    = TW'(OSR - 1);
   localparam logic [TW-1:0] STOP1_LOAD  = TW'(OSR - 2);
   localparam logic [TW-1:0] STOP15_LOAD = TW'((OSR * 3) / 2 - 2);
   localparam logic [TW-1:0] STOP2_LOAD  = TW'(2 * OSR - 2);

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

   state_t          state, state_n;
   logic [TW-1:0]   tick, tick_n, stop_load;
   logic [2:0]      bit_cnt, bit_n;
   logic [7:0]      shifter, shifter_n;
   logic            par_q, par_n, pen_q, pen_n, stb_q, stb_n, line_n;
   logic [1:0]      wls_q, wls_n;

   logic [7:0]      mem [FIFO_DEPTH];
   logic [PW-1:0]   wr_ptr, rd_ptr;
   logic [LW-1:0]   level, level_n, cap;
   logic            fifoen_q, clear, full, pop, push, ovf_next;
   logic [7:0]      head, mask, head_m;
   logic            par_calc;

   // A mode change flushes storage exactly like an explicit clear.
   assign clear    = txclr_in | (fifoen_in != fifoen_q) | ~utrst_in;
   assign cap      = fifoen_in ? LW'(FIFO_DEPTH) : LW'(1);
   assign full     = (level >= cap);
   assign pop      = (state == IDLE) && bclk_in && (level != '0) && !clear;
   assign push     = thr_wr_in && !clear && (!full || pop);
   assign ovf_next = thr_wr_in && !clear && full && !pop;
   assign head     = mem[rd_ptr];
   assign tx_level_out = level;

   always_comb begin
      level_n = level;
      if (clear)
         level_n = '0;
      else if (push && !pop)
         level_n = level + 1'b1;
      else if (pop && !push)
         level_n = level - 1'b1;
   end

   always_ff @(posedge apb_clk_in) begin
      if (apb_rst_in) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         level      <= '0;
         tx_ovf_out <= 1'b0;
         fifoen_q   <= fifoen_in;
      end else begin
         fifoen_q   <= fifoen_in;
         tx_ovf_out <= ovf_next;
         level      <= level_n;
         if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
         end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
         end
      end
   end

   always_ff @(posedge apb_clk_in) begin
      if (push) mem[wr_ptr] <= thr_in;
   end

   always_comb begin
      case (wls_in)
         2'b00:   mask = 8'h1F;
         2'b01:   mask = 8'h3F;
         2'b10:   mask = 8'h7F;
         default: mask = 8'hFF;
      endcase
      head_m   = head & mask;
      par_calc = sp_in ? ~eps_in : (eps_in ? ^head_m : ~^head_m);
   end

   // STOP runs one tick short; the IDLE tick that pops the next byte completes it.
   always_comb begin
      if (!stb_q)
         stop_load = STOP1_LOAD;
      else if (wls_q == 2'b00)
         stop_load = STOP15_LOAD;
      else
         stop_load = STOP2_LOAD;
   end

   always_comb begin
      state_n   = state;
      tick_n    = tick;
      bit_n     = bit_cnt;
      shifter_n = shifter;
      par_n     = par_q;
      wls_n     = wls_q;
      pen_n     = pen_q;
      stb_n     = stb_q;
      if (!utrst_in) begin
         state_n   = IDLE;
         tick_n    = '0;
         bit_n     = '0;
         shifter_n = '0;
      end else if (bclk_in) begin
         case (state)
            IDLE: begin
               if (pop) begin
                  state_n   = START;
                  tick_n    = BIT_LOAD;
                  bit_n     = '0;
                  shifter_n = head;
                  wls_n     = wls_in;
                  pen_n     = pen_in;
                  stb_n     = stb_in;
                  par_n     = par_calc;
               end
            end
            START: begin
               if (tick == '0) begin
                  state_n = DATA;
                  tick_n  = BIT_LOAD;
               end else
                  tick_n = tick - 1'b1;
            end
            DATA: begin
               if (tick == '0) begin
                  shifter_n = {1'b0, shifter[7:1]};
                  bit_n     = bit_cnt + 1'b1;
                  tick_n    = BIT_LOAD;
                  if (bit_cnt == {1'b1, wls_q}) begin
                     state_n = pen_q ? PARITY : STOP;
                     tick_n  = pen_q ? BIT_LOAD : stop_load;
                  end
               end else
                  tick_n = tick - 1'b1;
            end
            PARITY: begin
               if (tick == '0) begin
                  state_n = STOP;
                  tick_n  = stop_load;
               end else
                  tick_n = tick - 1'b1;
            end
            STOP: begin
               if (tick == '0) begin
                  state_n = IDLE;
                  tick_n  = '0;
               end else
                  tick_n = tick - 1'b1;
            end
            default: begin
               state_n = IDLE;
               tick_n  = '0;
            end
         endcase
      end
   end

   always_comb begin
      case (state_n)
         START:   line_n = 1'b0;
         DATA:    line_n = shifter_n[0];
         PARITY:  line_n = par_n;
         default: line_n = 1'b1;
      endcase
   end

   always_ff @(posedge apb_clk_in) begin
      if (apb_rst_in) begin
         state        <= IDLE;
         tick         <= '0;
         bit_cnt      <= '0;
         shifter      <= '0;
         par_q        <= 1'b0;
         wls_q        <= 2'b00;
         pen_q        <= 1'b0;
         stb_q        <= 1'b0;
         uart_txd_out <= 1'b1;
         thre_out     <= 1'b1;
         temt_out     <= 1'b1;
      end else begin
         state        <= state_n;
         tick         <= tick_n;
         bit_cnt      <= bit_n;
         shifter      <= shifter_n;
         par_q        <= par_n;
         wls_q        <= wls_n;
         pen_q        <= pen_n;
         stb_q        <= stb_n;
         uart_txd_out <= bc_in ? 1'b0 : line_n;
         thre_out     <= (level_n == '0);
         temt_out     <= (level_n == '0) && (state_n == IDLE);
      end
   end

endmodule
